// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions: symbol modes, fixed control/guard codes,
// the TERC4 data-island table and a small popcount helper.
package hdmi_pkg;

    typedef enum logic [2:0] {
        MODE_CTRL         = 3'd0,
        MODE_VIDEO        = 3'd1,
        MODE_VIDEO_GUARD  = 3'd2,
        MODE_ISLAND       = 3'd3,
        MODE_ISLAND_GUARD = 3'd4
    } tmds_mode_t;

    // Control-period symbols indexed by {c1,c0}.
    localparam logic [9:0] CTRL_CODE [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    localparam logic [9:0] VIDEO_GUARD_CN02  = 10'b1011001100;
    localparam logic [9:0] VIDEO_GUARD_CN1   = 10'b0100110011;
    localparam logic [9:0] ISLAND_GUARD_CN12 = 10'b0100110011;

    // TERC4 encoding of a data-island nibble.
    function automatic logic [9:0] terc4_encode(input logic [3:0] nibble);
        logic [9:0] sym;
        unique case (nibble)
            4'h0: sym = 10'b1010011100;
            4'h1: sym = 10'b1001100011;
            4'h2: sym = 10'b1011100100;
            4'h3: sym = 10'b1011100010;
            4'h4: sym = 10'b0101110001;
            4'h5: sym = 10'b0100011110;
            4'h6: sym = 10'b0110001110;
            4'h7: sym = 10'b0100111100;
            4'h8: sym = 10'b1011001100;
            4'h9: sym = 10'b0100111001;
            4'hA: sym = 10'b0110011100;
            4'hB: sym = 10'b1011000110;
            4'hC: sym = 10'b1010001110;
            4'hD: sym = 10'b1001110001;
            4'hE: sym = 10'b0101100011;
            default: sym = 10'b1011000011;
        endcase
        return sym;
    endfunction

    // Number of set bits in a byte (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: two-stage pipeline turning video, control, TERC4 or
// guard-band input into the 10-bit symbol fed to the 10:1 serializer.
module tmds_channel_encoder
    import hdmi_pkg::*;
#(
    parameter int CN = 0
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic [7:0] video_data,
    input  logic [1:0] control_data,
    input  logic [3:0] data_island_data,
    output logic [9:0] tmds,
    output logic [4:0] disparity
);

    // Stage-1 state
    tmds_mode_t mode_d, mode_q;
    logic [1:0] ctrl_q;
    logic [3:0] island_q;
    logic [8:0] qm_d, qm_q;
    logic [3:0] n1_d, n1_q;
    logic [3:0] n1d;
    logic       use_xnor;

    // Stage-2 state
    logic [9:0]        tmds_d, tmds_q;
    logic signed [4:0] cnt_d, cnt_q;
    logic signed [4:0] n1s, n0s, bal;

    // Stage 1: transition-minimise the pixel byte and fold invalid modes into CTRL.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
        n1d      = popcount8(video_data);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !video_data[0]);
        qm_d     = '0;
        qm_d[0]  = video_data[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ video_data[i]) : (qm_d[i-1] ^ video_data[i]);
        end
        qm_d[8]  = ~use_xnor;
        n1_d     = popcount8(qm_d[7:0]);
        mode_d   = (mode > 3'd4) ? MODE_CTRL : tmds_mode_t'(mode);
    end

    // Stage-1 pipeline registers; reset leaves a CTRL/00 symbol in flight.
    always_ff @(posedge clk_pixel or posedge reset) begin
        // NOTE: pipeline state is plain flops, so all of it is reset; state uses non-blocking assignments only.
        if (reset) begin
            mode_q   <= MODE_CTRL;
            ctrl_q   <= 2'b00;
            island_q <= 4'h0;
            qm_q     <= '0;
            n1_q     <= '0;
        end else begin
            mode_q   <= mode_d;
            ctrl_q   <= control_data;
            island_q <= data_island_data;
            qm_q     <= qm_d;
            n1_q     <= n1_d;
        end
    end

    // Stage 2: DC-balance video against the running disparity, or emit a fixed code.
    always_comb begin
        n1s    = $signed({1'b0, n1_q});
        n0s    = 5'sd8 - n1s;
        bal    = n1s - n0s;
        tmds_d = CTRL_CODE[0];
        cnt_d  = 5'sd0;
        case (mode_q)
            MODE_VIDEO: begin
                if ((cnt_q == 5'sd0) || (n1s == n0s)) begin
                    tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_d  = qm_q[8] ? (cnt_q + bal) : (cnt_q - bal);
                end else if (((cnt_q > 5'sd0) && (bal > 5'sd0)) ||
                             ((cnt_q < 5'sd0) && (bal < 5'sd0))) begin
                    tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                    cnt_d  = cnt_q - bal + (qm_q[8] ? 5'sd2 : 5'sd0);
                end else begin
                    tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
                    cnt_d  = cnt_q + bal - (qm_q[8] ? 5'sd0 : 5'sd2);
                end
            end
            MODE_VIDEO_GUARD:  tmds_d = (CN == 1) ? VIDEO_GUARD_CN1 : VIDEO_GUARD_CN02;
            MODE_ISLAND:       tmds_d = terc4_encode(island_q);
            MODE_ISLAND_GUARD: tmds_d = (CN == 0) ? terc4_encode(island_q) : ISLAND_GUARD_CN12;
            default:           tmds_d = CTRL_CODE[ctrl_q];
        endcase
    end

    // Stage-2 output register and running disparity.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            tmds_q <= CTRL_CODE[0];
            cnt_q  <= 5'sd0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds      = tmds_q;
    assign disparity = cnt_q;

endmodule
